// File: rtl/ascon_round_sequencer.sv
// Round-index sequencer for the Ascon permutation: a start/done handshake around an N-round
// counter that walks the constant schedule 12-N..11. Optional abort input: `ASCON_SEQ_ABORT_EN.
module ascon_round_sequencer #(
  parameter int NB_ROUNDS_A = 12,
  parameter int NB_ROUNDS_B = 6,
  parameter int ROUND_W     = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_mode,
  input  logic               i_done_ack,
`ifdef ASCON_SEQ_ABORT_EN
  input  logic               i_abort,
`endif
  output logic               o_ready,
  output logic               o_state_load,
  output logic [ROUND_W-1:0] o_round,
  output logic               o_round_valid,
  output logic               o_first_round,
  output logic               o_last_round,
  output logic               o_done
);

  if (NB_ROUNDS_A < 1 || NB_ROUNDS_A > 12 || NB_ROUNDS_B < 1 || NB_ROUNDS_B > 12 || ROUND_W != 4)
  begin : g_bad_param
    $fatal(1, "ascon_round_sequencer: round counts must be 1..12 and ROUND_W must be 4");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // An N-round call starts at index 12-N so its last round always uses constant 11.
  localparam logic [ROUND_W-1:0] START_A    = ROUND_W'(12 - NB_ROUNDS_A);
  localparam logic [ROUND_W-1:0] START_B    = ROUND_W'(12 - NB_ROUNDS_B);
  localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(11);

  state_e             state_q;
  logic [ROUND_W-1:0] round_q;
  logic [ROUND_W-1:0] round_d;
  logic [ROUND_W-1:0] start_idx_d;
  logic               valid_q;
  logic               first_q;
  logic               last_q;
  logic               done_q;
  logic               accept;
  logic               abort_w;

`ifdef ASCON_SEQ_ABORT_EN
  assign abort_w = i_abort;
`else
  assign abort_w = 1'b0;
`endif

  assign accept      = i_start && (state_q == ST_IDLE);
  assign round_d     = round_q + ROUND_W'(1);
  assign start_idx_d = i_mode ? START_B : START_A;

  // NOTE: state registers use non-blocking assignments only, so every update in this block
  // sees the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      round_q <= '0;
      valid_q <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_q <= ST_RUN;
            round_q <= start_idx_d;
            valid_q <= 1'b1;
            first_q <= 1'b1;
            last_q  <= (start_idx_d == LAST_ROUND);
          end
        end
        ST_RUN: begin
          if (abort_w) begin
            state_q <= ST_IDLE;
            round_q <= '0;
            valid_q <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
          end else if (round_q == LAST_ROUND) begin
            // Index holds at 11 through DONE; the counter never wraps.
            state_q <= ST_DONE;
            valid_q <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            round_q <= round_d;
            first_q <= 1'b0;
            last_q  <= (round_d == LAST_ROUND);
          end
        end
        ST_DONE: begin
          if (abort_w || i_done_ack) begin
            state_q <= ST_IDLE;
            round_q <= '0;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          round_q <= '0;
          valid_q <= 1'b0;
          first_q <= 1'b0;
          last_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_ready       = (state_q == ST_IDLE);
  assign o_state_load  = accept;
  assign o_round       = round_q;
  assign o_round_valid = valid_q;
  assign o_first_round = first_q;
  assign o_last_round  = last_q;
  assign o_done        = done_q;

endmodule

// File: tb/tb_ascon_round_sequencer.sv
// Directed bench for ascon_round_sequencer: default (12/6), NB_ROUNDS_B=8 and NB_ROUNDS_B=1
// instances share stimulus; abort scenario only when ASCON_SEQ_ABORT_EN is defined.
module tb_ascon_round_sequencer;

  logic clk = 1'b0;
  logic rst, start, mode, ack, abort;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  logic       rdy_m, ld_m, val_m, fst_m, lst_m, dn_m;
  logic [3:0] rnd_m;
  logic       rdy_8, ld_8, val_8, fst_8, lst_8, dn_8;
  logic [3:0] rnd_8;
  logic       rdy_1, ld_1, val_1, fst_1, lst_1, dn_1;
  logic [3:0] rnd_1;

  ascon_round_sequencer #(.NB_ROUNDS_A(12), .NB_ROUNDS_B(6), .ROUND_W(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_mode(mode), .i_done_ack(ack),
`ifdef ASCON_SEQ_ABORT_EN
    .i_abort(abort),
`endif
    .o_ready(rdy_m), .o_state_load(ld_m), .o_round(rnd_m), .o_round_valid(val_m),
    .o_first_round(fst_m), .o_last_round(lst_m), .o_done(dn_m));

  ascon_round_sequencer #(.NB_ROUNDS_A(12), .NB_ROUNDS_B(8), .ROUND_W(4)) dut_b8 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_mode(mode), .i_done_ack(ack),
`ifdef ASCON_SEQ_ABORT_EN
    .i_abort(abort),
`endif
    .o_ready(rdy_8), .o_state_load(ld_8), .o_round(rnd_8), .o_round_valid(val_8),
    .o_first_round(fst_8), .o_last_round(lst_8), .o_done(dn_8));

  ascon_round_sequencer #(.NB_ROUNDS_A(12), .NB_ROUNDS_B(1), .ROUND_W(4)) dut_b1 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_mode(mode), .i_done_ack(ack),
`ifdef ASCON_SEQ_ABORT_EN
    .i_abort(abort),
`endif
    .o_ready(rdy_1), .o_state_load(ld_1), .o_round(rnd_1), .o_round_valid(val_1),
    .o_first_round(fst_1), .o_last_round(lst_1), .o_done(dn_1));

  // Packed status: {ready, state_load, round_valid, first, last, done, round[3:0]}
  logic [9:0] st_m, st_8, st_1;
  assign st_m = {rdy_m, ld_m, val_m, fst_m, lst_m, dn_m, rnd_m};
  assign st_8 = {rdy_8, ld_8, val_8, fst_8, lst_8, dn_8, rnd_8};
  assign st_1 = {rdy_1, ld_1, val_1, fst_1, lst_1, dn_1, rnd_1};

  localparam logic [9:0] IDLE_ST = 10'b10_0000_0000;
  localparam logic [9:0] LOAD_ST = 10'b11_0000_0000;
  localparam logic [9:0] DONE_ST = {6'b000001, 4'd11};

  function automatic logic [9:0] run_st(input int r, input int first_r);
    run_st = {3'b001, (r == first_r), (r == 11), 1'b0, 4'(r)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; mode = 1'b0; ack = 1'b0; abort = 1'b0;
    tick(); tick();
    rst = 1'b0;
    n_vec++;
    if (st_m !== IDLE_ST) begin n_err++; $display("FAIL reset_main got %b want %b", st_m, IDLE_ST); end
    n_vec++;
    if ({st_8, st_1} !== {IDLE_ST, IDLE_ST}) begin
      n_err++; $display("FAIL reset_param got %b/%b want %b", st_8, st_1, IDLE_ST);
    end
  endtask

  task automatic test_mode0();
    start = 1'b1; mode = 1'b0;
    #1;
    n_vec++;
    if (st_m !== LOAD_ST) begin n_err++; $display("FAIL m0_accept got %b want %b", st_m, LOAD_ST); end
    tick();
    start = 1'b0;
    for (int r = 0; r < 12; r++) begin
      n_vec++;
      if (st_m !== run_st(r, 0)) begin
        n_err++; $display("FAIL m0_round%0d got %b want %b", r, st_m, run_st(r, 0));
      end
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (st_m !== DONE_ST) begin n_err++; $display("FAIL m0_done_hold%0d got %b want %b", k, st_m, DONE_ST); end
      tick();
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    n_vec++;
    if (st_m !== IDLE_ST) begin n_err++; $display("FAIL m0_ack got %b want %b", st_m, IDLE_ST); end
  endtask

  task automatic test_mode1();
    start = 1'b1; mode = 1'b1;
    tick();
    start = 1'b0; mode = 1'b0;
    for (int r = 6; r < 12; r++) begin
      n_vec++;
      if (st_m !== run_st(r, 6)) begin
        n_err++; $display("FAIL m1_round%0d got %b want %b", r, st_m, run_st(r, 6));
      end
      tick();
    end
    n_vec++;
    if (st_m !== DONE_ST) begin n_err++; $display("FAIL m1_done got %b want %b", st_m, DONE_ST); end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    n_vec++;
    if (st_m !== IDLE_ST) begin n_err++; $display("FAIL m1_ready got %b want %b", st_m, IDLE_ST); end
  endtask

  task automatic test_back_to_back();
    start = 1'b1; mode = 1'b0;
    tick();
    // Stray start (mode 1) and stray ack during RUN must not disturb the mode-0 sequence.
    for (int r = 0; r < 12; r++) begin
      start = r[0]; mode = 1'b1; ack = (r == 4);
      #1;
      n_vec++;
      if (st_m !== run_st(r, 0)) begin
        n_err++; $display("FAIL b2b_run%0d got %b want %b", r, st_m, run_st(r, 0));
      end
      tick();
    end
    start = 1'b1; ack = 1'b0;
    #1;
    n_vec++;
    if (st_m !== DONE_ST) begin n_err++; $display("FAIL b2b_start_in_done got %b want %b", st_m, DONE_ST); end
    tick();
    start = 1'b0;
    n_vec++;
    if (st_m !== DONE_ST) begin n_err++; $display("FAIL b2b_done_held got %b want %b", st_m, DONE_ST); end
    ack = 1'b1;                 // cycle X
    tick();
    ack = 1'b0; start = 1'b1; mode = 1'b1;   // cycle X+1
    #1;
    n_vec++;
    if (st_m !== LOAD_ST) begin n_err++; $display("FAIL b2b_accept got %b want %b", st_m, LOAD_ST); end
    tick();
    start = 1'b0; mode = 1'b0;  // cycle X+2
    n_vec++;
    if (st_m !== run_st(6, 6)) begin n_err++; $display("FAIL b2b_first got %b want %b", st_m, run_st(6, 6)); end
    repeat (6) tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    n_vec++;
    if (st_m !== IDLE_ST) begin n_err++; $display("FAIL b2b_end got %b want %b", st_m, IDLE_ST); end
  endtask

  task automatic test_reset_mid();
    start = 1'b1; mode = 1'b0;
    tick();
    start = 1'b0;
    repeat (5) tick();
    n_vec++;
    if (st_m !== run_st(5, 0)) begin n_err++; $display("FAIL rst_mid_pre got %b want %b", st_m, run_st(5, 0)); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      n_vec++;
      if (st_m !== IDLE_ST) begin n_err++; $display("FAIL rst_mid%0d got %b want %b", k, st_m, IDLE_ST); end
      tick();
    end
  endtask

  task automatic test_params();
    logic [9:0] e8, e1, em;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b1; mode = 1'b1;
    tick();
    start = 1'b0; mode = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      e8 = (k <= 8) ? run_st(3 + k, 4) : DONE_ST;
      e1 = (k == 1) ? run_st(11, 11) : DONE_ST;
      em = (k <= 6) ? run_st(5 + k, 6) : DONE_ST;
      n_vec++;
      if ({st_8, st_1, st_m} !== {e8, e1, em}) begin
        n_err++;
        $display("FAIL param_T+%0d got b8=%b b1=%b m=%b want b8=%b b1=%b m=%b", k, st_8, st_1, st_m, e8, e1, em);
      end
      tick();
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    n_vec++;
    if ({st_8, st_1, st_m} !== {IDLE_ST, IDLE_ST, IDLE_ST}) begin
      n_err++; $display("FAIL param_ack got %b/%b/%b want %b", st_8, st_1, st_m, IDLE_ST);
    end
  endtask

`ifdef ASCON_SEQ_ABORT_EN
  task automatic test_abort();
    start = 1'b1; mode = 1'b0;
    tick();
    start = 1'b0;
    repeat (3) tick();
    n_vec++;
    if (st_m !== run_st(3, 0)) begin n_err++; $display("FAIL abort_pre got %b want %b", st_m, run_st(3, 0)); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    for (int k = 0; k < 12; k++) begin
      n_vec++;
      if (st_m !== IDLE_ST) begin n_err++; $display("FAIL abort_run%0d got %b want %b", k, st_m, IDLE_ST); end
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b1; mode = 1'b1;
    tick();
    start = 1'b0; mode = 1'b0;
    repeat (6) tick();
    n_vec++;
    if (st_m !== DONE_ST) begin n_err++; $display("FAIL abort_done_pre got %b want %b", st_m, DONE_ST); end
    abort = 1'b1; ack = 1'b1;
    tick();
    abort = 1'b0; ack = 1'b0;
    n_vec++;
    if (st_m !== IDLE_ST) begin n_err++; $display("FAIL abort_vs_ack got %b want %b", st_m, IDLE_ST); end
    // Abort in IDLE is ignored while a concurrent start is accepted.
    abort = 1'b1; start = 1'b1; mode = 1'b1;
    #1;
    n_vec++;
    if (st_m !== LOAD_ST) begin n_err++; $display("FAIL abort_idle got %b want %b", st_m, LOAD_ST); end
    tick();
    abort = 1'b0; start = 1'b0; mode = 1'b0;
    n_vec++;
    if (st_m !== run_st(6, 6)) begin n_err++; $display("FAIL abort_idle_run got %b want %b", st_m, run_st(6, 6)); end
  endtask
`endif

  initial begin
    test_reset();
    test_mode0();
    test_mode1();
    test_back_to_back();
    test_reset_mid();
    test_params();
`ifdef ASCON_SEQ_ABORT_EN
    test_abort();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
